dt_frame_sequencer: RTL

// Front/back end for the combinational decision-tree fault classifier.
// - Accepts a serial stream of 8-bit phase samples, one channel per beat, in the order Va,Vb,Vc,Ia,Ib,Ic.
// - Assembles each 6-beat frame and presents it in parallel, stable, to the classifier.
// - Waits the classifier latency, captures its cls output and returns the result with a valid/ready handshake.

---
 rtl/dt_pkg.sv | 21 ++
 rtl/dt_frame_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/dt_pkg.sv
// rtl/dt_pkg.sv - shared types for the decision-tree frame sequencer
package dt_pkg;

  typedef enum logic [1:0] {
    COLLECT,
    EVAL,
    HOLD
  } dt_seq_state_t;

  localparam int NUM_CH = 6;

  typedef enum logic [2:0] {
    CH_VA,
    CH_VB,
    CH_VC,
    CH_IA,
    CH_IB,
    CH_IC
  } dt_ch_t;

endpackage

// File: rtl/dt_frame_sequencer.sv
// rtl/dt_frame_sequencer.sv - serial-to-frame assembler and result capture around the fault classifier
module dt_frame_sequencer
  import dt_pkg::*;
#(
  parameter int N      = 8,
  parameter int C      = 1,
  parameter int DT_LAT = 0,
  parameter int FID_W  = 8,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [N-1:0]     s_data,
  input  logic             s_first,
  output logic [N-1:0]     Va,
  output logic [N-1:0]     Vb,
  output logic [N-1:0]     Vc,
  output logic [N-1:0]     Ia,
  output logic [N-1:0]     Ib,
  output logic [N-1:0]     Ic,
  input  logic [C-1:0]     cls_in,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [C-1:0]     m_cls,
  output logic [FID_W-1:0] m_fid,
  output logic [ERR_W-1:0] err_cnt
);

  // A zero-latency classifier still needs a 1-bit counter so the datapath stays uniform.
  localparam int CNT_W = (DT_LAT > 0) ? $clog2(DT_LAT + 1) : 1;

  dt_seq_state_t    state, state_nxt;
  logic [2:0]       idx;
  logic [N-1:0]     shadow [NUM_CH-1];
  logic [CNT_W-1:0] wait_cnt;
  logic [FID_W-1:0] fid_cnt;
  logic             beat;
  logic             resync;
  logic             complete;
  logic             eval_done;

  // Next-state and beat qualification; s_ready depends on state only.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    beat      = 1'b0;
    resync    = 1'b0;
    complete  = 1'b0;
    eval_done = 1'b0;
    case (state)
      COLLECT: begin
        s_ready  = 1'b1;
        beat     = s_valid;
        resync   = beat && s_first && (idx != 3'(CH_VA));
        complete = beat && !resync && (idx == 3'(CH_IC));
        if (complete) state_nxt = EVAL;
      end
      EVAL: begin
        eval_done = (wait_cnt == '0);
        if (eval_done) state_nxt = HOLD;
      end
      HOLD: begin
        if (m_ready) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  // Frame assembly: shadow the first five channels, publish all six together on the last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= 3'(CH_VA);
      err_cnt <= '0;
      Va      <= '0;
      Vb      <= '0;
      Vc      <= '0;
      Ia      <= '0;
      Ib      <= '0;
      Ic      <= '0;
      for (int i = 0; i < NUM_CH - 1; i++) shadow[i] <= '0;
    end else if (resync) begin
      // A frame-start marker mid-frame drops the partial frame and restarts at Va.
      shadow[0] <= s_data;
      idx       <= 3'(CH_VB);
      if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
    end else if (complete) begin
      Va  <= shadow[0];
      Vb  <= shadow[1];
      Vc  <= shadow[2];
      Ia  <= shadow[3];
      Ib  <= shadow[4];
      Ic  <= s_data;
      idx <= 3'(CH_VA);
    end else if (beat) begin
      shadow[idx] <= s_data;
      idx         <= idx + 3'd1;
    end
  end

  // Classifier wait, result capture and result handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      fid_cnt  <= '0;
      m_valid  <= 1'b0;
      m_cls    <= '0;
      m_fid    <= '0;
    end else begin
      if (complete) begin
        wait_cnt <= CNT_W'(DT_LAT);
      end else if (state == EVAL && !eval_done) begin
        wait_cnt <= wait_cnt - CNT_W'(1);
      end

      if (eval_done) begin
        m_cls   <= cls_in;
        m_fid   <= fid_cnt;
        m_valid <= 1'b1;
        fid_cnt <= fid_cnt + FID_W'(1);
      end else if (state == HOLD && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
